// File: rtl/common.sv
// rtl/common.sv - shared data-bus request/response types
package common;

   typedef logic [63:0] u64;
   typedef u64          word_t;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      u64          addr;
      msize_t      size;
      logic [7:0]  strobe;
      word_t       data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      word_t       data;
   } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder_pkg.sv
// rtl/dbus_sram_responder_pkg.sv - responder state, latency bound and alignment helper
package dbus_sram_responder_pkg;
   import common::*;

   typedef enum logic [1:0] {
      RSP_IDLE = 2'd0,
      RSP_WAIT = 2'd1,
      RSP_RESP = 2'd2
   } rsp_state_t;

   localparam int RSP_MAX_LATENCY = 15;
   localparam int RSP_CNT_W       = $clog2(RSP_MAX_LATENCY + 1);

   // size encodes log2 of the access width in bytes
   function automatic logic rsp_misaligned(input u64 addr, input msize_t size);
      logic bad;
      bad = 1'b0;
      case (size)
         MSIZE2:  bad = addr[0];
         MSIZE4:  bad = |addr[1:0];
         MSIZE8:  bad = |addr[2:0];
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dbus_sram_responder_sram_bytewrite.sv
// rtl/dbus_sram_responder_sram_bytewrite.sv - DEPTH x 64 array, byte-lane writes, registered read
module sram_bytewrite #(
   parameter int DEPTH = 1024
) (
   input  logic                       clk,
   input  logic [7:0]                 we_i,
   input  logic [$clog2(DEPTH)-1:0]   widx_i,
   input  logic [63:0]                wdata_i,
   input  logic [$clog2(DEPTH)-1:0]   ridx_i,
   output logic [63:0]                rdata_o
);

   logic [63:0] mem_q [DEPTH];
   logic [63:0] rdata_q;

   // read and write share an edge; the read returns the pre-write word
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (we_i[i]) begin
            mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
      rdata_q <= mem_q[ridx_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// rtl/dbus_sram_responder.sv - data-bus responder over a word SRAM with LATENCY wait states
// Optional DBUS_MISALIGN_CHECK_EN adds the misalign output and suppresses misaligned writes.
module dbus_sram_responder
   import common::*;
   import dbus_sram_responder_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       busy
`ifdef DBUS_MISALIGN_CHECK_EN
   ,
   output logic       misalign
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   rsp_state_t             state_q;
   logic [RSP_CNT_W-1:0]   cnt_q;
   logic [IDX_W-1:0]       idx_q;
   logic [7:0]             strobe_q;
   word_t                  wdata_q;
   logic                   resp_q;
   logic                   busy_q;
   logic                   bad_q;
   logic                   misalign_q;

   logic [IDX_W-1:0]       req_idx;
   logic                   req_bad;
   logic [IDX_W-1:0]       ridx;
   logic [7:0]             we;
   word_t                  rdata;
   logic                   unused_req;

   assign req_idx    = dreq.addr[IDX_W+2:3];
   assign unused_req = ^{dreq.addr, dreq.size};

`ifdef DBUS_MISALIGN_CHECK_EN
   assign req_bad = rsp_misaligned(dreq.addr, dreq.size);
`else
   assign req_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= RSP_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         strobe_q   <= '0;
         wdata_q    <= '0;
         resp_q     <= 1'b0;
         busy_q     <= 1'b0;
         bad_q      <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         resp_q     <= 1'b0;
         misalign_q <= 1'b0;
         case (state_q)
            RSP_IDLE: begin
               if (dreq.valid) begin
                  idx_q    <= req_idx;
                  strobe_q <= dreq.strobe;
                  wdata_q  <= dreq.data;
                  bad_q    <= req_bad;
                  busy_q   <= 1'b1;
                  if (LATENCY == 0) begin
                     state_q    <= RSP_RESP;
                     resp_q     <= 1'b1;
                     misalign_q <= req_bad;
                  end else begin
                     cnt_q   <= RSP_CNT_W'(LATENCY - 1);
                     state_q <= RSP_WAIT;
                  end
               end
            end
            RSP_WAIT: begin
               // a requester that withdraws mid-wait gets neither write nor response
               if (!dreq.valid) begin
                  state_q <= RSP_IDLE;
                  busy_q  <= 1'b0;
               end else if (cnt_q == '0) begin
                  state_q    <= RSP_RESP;
                  resp_q     <= 1'b1;
                  misalign_q <= bad_q;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RSP_RESP: begin
               state_q <= RSP_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= RSP_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // while idle the array is read at the incoming index so a zero-latency response is ready
   assign ridx = (state_q == RSP_IDLE) ? req_idx : idx_q;
   assign we   = (reset && state_q == RSP_RESP && !bad_q) ? strobe_q : 8'h00;

   sram_bytewrite #(
      .DEPTH (DEPTH)
   ) u_sram (
      .clk     (clk),
      .we_i    (we),
      .widx_i  (idx_q),
      .wdata_i (wdata_q),
      .ridx_i  (ridx),
      .rdata_o (rdata)
   );

   assign dresp.addr_ok = resp_q;
   assign dresp.data_ok = resp_q;
   assign dresp.data    = (resp_q && !misalign_q) ? rdata : '0;
   assign busy          = busy_q;

`ifdef DBUS_MISALIGN_CHECK_EN
   assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb/tb_dbus_sram_responder.sv - directed checks of the responder at LATENCY 2 and 0
module tb_dbus_sram_responder;
   import common::*;

   logic       clk;
   logic       reset;
   dbus_req_t  dreq_a, dreq_b;
   dbus_resp_t dresp_a, dresp_b;
   logic       busy_a, busy_b;
`ifdef DBUS_MISALIGN_CHECK_EN
   logic       misalign_a, misalign_b;
   logic       mis_seen;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   dbus_sram_responder #(.DEPTH(1024), .LATENCY(2)) u_dut_a (
      .clk      (clk),
      .reset    (reset),
      .dreq     (dreq_a),
      .dresp    (dresp_a),
      .busy     (busy_a)
`ifdef DBUS_MISALIGN_CHECK_EN
      ,
      .misalign (misalign_a)
`endif
   );

   dbus_sram_responder #(.DEPTH(1024), .LATENCY(0)) u_dut_b (
      .clk      (clk),
      .reset    (reset),
      .dreq     (dreq_b),
      .dresp    (dresp_b),
      .busy     (busy_b)
`ifdef DBUS_MISALIGN_CHECK_EN
      ,
      .misalign (misalign_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int w, input dbus_req_t r);
      if (w == 0) dreq_a = r;
      else        dreq_b = r;
   endtask

   function automatic dbus_req_t mk(input logic v, input u64 addr, input msize_t sz,
                                    input logic [7:0] stb, input word_t wd);
      dbus_req_t r;
      r.valid = v; r.addr = addr; r.size = sz; r.strobe = stb; r.data = wd;
      return r;
   endfunction

   // called at a negedge; k counts the rising edges passed since valid was raised
   task automatic txn(input int w, input u64 addr, input msize_t sz, input logic [7:0] stb,
                      input word_t wd, output word_t rd, output int lat);
      dbus_req_t  r;
      dbus_resp_t s;
      bit         got;
      got = 1'b0;
      rd  = '0;
      lat = -1;
      r   = mk(1'b1, addr, sz, stb, wd);
      set_req(w, r);
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         s = (w == 0) ? dresp_a : dresp_b;
         if (s.data_ok) begin
            got = 1'b1;
            lat = k;
            rd  = s.data;
`ifdef DBUS_MISALIGN_CHECK_EN
            mis_seen = (w == 0) ? misalign_a : misalign_b;
`endif
            r.valid = 1'b0;
            set_req(w, r);
         end
      end
      check("resp_seen", 64'(got), 64'd1);
      @(negedge clk);
      s = (w == 0) ? dresp_a : dresp_b;
      check("data_ok_width", 64'(s.data_ok), 64'd0);
   endtask

   initial begin
      word_t rd;
      int    lat;
      int    nh;
      int    hits [2];
      word_t hdat [2];

      reset  = 1'b0;
      dreq_a = '0;
      dreq_b = '0;
      repeat (3) @(negedge clk);
      check("rst_addr_ok", 64'(dresp_a.addr_ok), 64'd0);
      check("rst_data_ok", 64'(dresp_a.data_ok), 64'd0);
      check("rst_data",    dresp_a.data,         64'd0);
      check("rst_busy",    64'(busy_a),          64'd0);
      check("rst_busy_b",  64'(busy_b),          64'd0);
      reset = 1'b1;
      @(negedge clk);

      txn(0, 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122334455667788, rd, lat);
      check("wr_latency", 64'(lat), 64'd2);
      txn(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, rd, lat);
      check("rd_full", rd, 64'h1122334455667788);

      // reset held for three cycles while a write waits
      set_req(0, mk(1'b1, 64'h8000_0010, MSIZE8, 8'hFF, 64'hDEADBEEFDEADBEEF));
      @(negedge clk);
      check("midrst_busy", 64'(busy_a), 64'd1);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_no_resp", 64'(dresp_a.data_ok), 64'd0);
      end
      dreq_a.valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("midrst_idle", 64'(busy_a), 64'd0);
      txn(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, rd, lat);
      check("midrst_no_write", rd, 64'h1122334455667788);

      txn(0, 64'h8000_0010, MSIZE8, 8'h0F, 64'hAAAAAAAAAAAAAAAA, rd, lat);
      check("partial_prewrite", rd, 64'h1122334455667788);
      txn(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, rd, lat);
      check("partial_merged", rd, 64'h11223344AAAAAAAA);

      // withdraw a write during WAIT, then issue a read on the following cycle
      set_req(0, mk(1'b1, 64'h8000_0010, MSIZE8, 8'hFF, 64'h5555555555555555));
      @(negedge clk);
      check("abort_busy", 64'(busy_a), 64'd1);
      dreq_a.valid = 1'b0;
      @(negedge clk);
      check("abort_idle", 64'(busy_a), 64'd0);
      check("abort_no_resp", 64'(dresp_a.data_ok), 64'd0);
      txn(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, rd, lat);
      check("abort_unchanged", rd, 64'h11223344AAAAAAAA);
      check("abort_next_lat", 64'(lat), 64'd2);

      txn(0, 64'h0000_0018, MSIZE8, 8'hFF, 64'h0F0E0D0C0B0A0908, rd, lat);
      txn(0, 64'h8000_0018, MSIZE8, 8'h00, 64'h0, rd, lat);
      check("wrap_hi_addr", rd, 64'h0F0E0D0C0B0A0908);
      txn(0, 64'h0000_2018, MSIZE8, 8'h00, 64'h0, rd, lat);
      check("wrap_idx1027", rd, 64'h0F0E0D0C0B0A0908);

`ifdef DBUS_MISALIGN_CHECK_EN
      txn(0, 64'h8000_0012, MSIZE4, 8'hFF, 64'h0BAD0BAD0BAD0BAD, rd, lat);
      check("mis_flag", 64'(mis_seen), 64'd1);
      check("mis_data", rd, 64'd0);
      check("mis_idle_flag", 64'(misalign_a), 64'd0);
      txn(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, rd, lat);
      check("mis_unchanged", rd, 64'h11223344AAAAAAAA);
      check("mis_aligned_flag", 64'(mis_seen), 64'd0);
`endif

      txn(1, 64'h0000_0000, MSIZE8, 8'hFF, 64'h0101010101010101, rd, lat);
      check("l0_latency", 64'(lat), 64'd0);
      txn(1, 64'h0000_0008, MSIZE8, 8'hFF, 64'h0202020202020202, rd, lat);

      // back-to-back reads at idx 0 then idx 1 with zero latency
      nh = 0;
      hits[0] = -1; hits[1] = -1;
      hdat[0] = '0; hdat[1] = '0;
      set_req(1, mk(1'b1, 64'h0, MSIZE8, 8'h00, 64'h0));
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (dresp_b.data_ok) begin
            if (nh < 2) begin
               hits[nh] = k;
               hdat[nh] = dresp_b.data;
            end
            nh++;
            if (nh == 1) set_req(1, mk(1'b1, 64'h8, MSIZE8, 8'h00, 64'h0));
            else         dreq_b.valid = 1'b0;
         end
      end
      check("b2b_count", 64'(nh), 64'd2);
      check("b2b_first_cyc", 64'(hits[0]), 64'd0);
      check("b2b_second_cyc", 64'(hits[1]), 64'd2);
      check("b2b_data0", hdat[0], 64'h0101010101010101);
      check("b2b_data1", hdat[1], 64'h0202020202020202);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Responder end of the data bus used by the memory stage: accepts `dbus_req_t` requests and returns `dbus_resp_t` responses from an internal word-organised SRAM array.
- Serves as the data-memory model behind the memory stage for simulation and for bring-up.
- The wait-state latency is configurable, so the memory stage's stall and handshake paths are exercised.

Parameters:
- DEPTH, 1024, number of 64-bit words in the array; power of two.
- LATENCY, 2, wait cycles between sampling a request and responding; 0..15.
- IDX_W, $clog2(DEPTH), word-index width; derived, not overridable.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- dreq  in  $bits(dbus_req_t)  request: valid, addr (u64), size (msize_t), strobe (8 bits, byte lanes), data (word_t).
- dresp  out  $bits(dbus_resp_t)  response: addr_ok, data_ok, data (word_t).
- busy  out  1  high while a request is in flight (states WAIT or RESP).

Behaviour:
- One clock. Reset is synchronous and active-low; it is sampled on the rising clk edge while reset==0.
- Reset outputs: dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0, busy=0. State=IDLE, counter=0.
- The array contents are not cleared by reset.
- Index: idx = dreq.addr[IDX_W+2:3]. Upper address bits and addr[2:0] are ignored; addresses wrap modulo DEPTH words.
- Requester rule: dreq is held stable from the cycle valid rises until the cycle data_ok is seen high.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If dreq.valid=1 at an edge, latch idx, strobe and wdata.
  - If LATENCY=0, go to RESP; otherwise load cnt=LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement cnt each cycle; at cnt==0, go to RESP.
  - If dreq.valid drops, abort: go to IDLE, no write, no response.
- RESP:
  - addr_ok=1 and data_ok=1 for exactly one cycle.
  - dresp.data = array word at the latched idx, read on entry to RESP, i.e. the pre-write contents.
  - On the edge leaving RESP: for each byte lane i with strobe[i]=1, array[idx][8i+7:8i] <= wdata[8i+7:8i]. strobe=0 means a read.
  - Next state is always IDLE. A new request is accepted no earlier than the cycle after RESP, giving back-to-back spacing of LATENCY+2 cycles.
- Response timing: a request first sampled at edge t produces data_ok high in cycle t+LATENCY+1.
- dresp.data outside RESP is 0.
- size is not used for data steering; strobe is authoritative.
- Reset asserted mid-operation: return to IDLE, drop the pending request, perform no write. Array writes are inhibited in any cycle where reset==0.
- Read-after-write to the same address: the later read returns the merged data, because requests are strictly serialised.

Optional Feature:
- Macro: DBUS_MISALIGN_CHECK_EN.
- When defined:
  - Adds output `misalign` (1 bit, reset 0).
  - A request is misaligned if addr is not a multiple of (1<<size).
  - A misaligned request still completes the handshake normally, but:
    - the write is suppressed;
    - dresp.data = 0;
    - misalign=1 in the RESP cycle only.
- When not defined: no `misalign` port; alignment is not checked and data is written per strobe.

Decomposition:
- Existing `common` package already provides dbus_req_t, dbus_resp_t, msize_t, word_t and u64.
- Shared package adds:
  - the responder state enum: RSP_IDLE, RSP_WAIT, RSP_RESP;
  - a constant for the maximum LATENCY (15).
- Natural sub-module: `sram_bytewrite`, a DEPTH×64 array with 8 byte-lane write enables and a synchronous read. The FSM stays in the top module.

Test Plan:
- Reset with LATENCY=2 → all dresp fields and busy are 0. Hold reset low 3 cycles during an active request → no response, no write.
- Write addr=0x80000010, strobe=0xFF, data=0x1122334455667788, valid at edge 0 → data_ok high only in cycle 3. Then read addr=0x80000010 → data 0x1122334455667788.
- Partial write strobe=0x0F, data=0xAAAAAAAAAAAAAAAA to the same word → subsequent read returns 0x11223344AAAAAAAA.
- LATENCY=0, back-to-back reads at idx 0 and 1 → each data_ok one cycle wide, with responses 2 cycles apart.
- Valid dropped during WAIT on a write → array unchanged (read returns the old value); FSM accepts a new request next cycle.
- With DBUS_MISALIGN_CHECK_EN, size=word (4B) at addr=0x80000012 write → misalign=1 in the RESP cycle, data=0, memory unchanged. Addr 0x80000018 address wrap with DEPTH=1024 covered by reading idx 3.
